// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and defaults for note playback
// Purpose: player FSM state type and default slot/latency values that the
//          playback sequencer and the note datapath must agree on.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TONE = 2'd2,
    GAP  = 2'd3
  } player_state_t;

  // Address register plus RAM output register in the datapath.
  localparam int LOAD_CYCLES_DEF = 2;
  localparam int NUM_NOTES_DEF   = 16;

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator driven by a half-period length
// Purpose: toggles wave every half_period clk cycles while enabled.
// Ports:
//   clk, reset (sync, active-low)
//   enable       : 0 clears the counter and forces wave low
//   half_period  : half-period length in clk cycles, 0 = rest (wave stays low)
//   wave         : registered square-wave output
module tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] half_period,
  output logic        wave
);

  logic [31:0] cnt_q;
  logic        wave_q;

  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      cnt_q  <= 32'd0;
      wave_q <= 1'b0;
    end else if (half_period == 32'd0) begin
      // A zero length would underflow the terminal compare; treat as rest.
      cnt_q  <= 32'd0;
      wave_q <= 1'b0;
    end else if (cnt_q == half_period - 32'd1) begin
      cnt_q  <= 32'd0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q  <= cnt_q + 32'd1;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - playback sequencer for the note store
// Purpose: walks note_counter through the memory slots, waits for the fetched
//          frequency word, plays it as a square wave for NOTE_CYCLES, then
//          stays silent for GAP_CYCLES before the next slot.
// Ports:
//   clk, reset (sync, active-low)
//   play         : start request, only looked at while idle
//   stop         : abort from any state, wins over play
//   loop_en      : wrap to slot 0 after the last slot instead of finishing
//   freq_in      : half-period of the fetched note in clk cycles, 0 = rest
//   note_counter : current memory slot
//   ld_play      : datapath read select, high whenever not idle
//   next_note_en : one-cycle pulse on entering the tone phase
//   audio_out    : square-wave output
//   busy         : high whenever not idle
//   done         : one-cycle pulse when a non-looping pass completes
module note_player
  import music_pkg::*;
#(
  parameter int NUM_NOTES   = NUM_NOTES_DEF,
  parameter int ADDR_W      = 4,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [31:0]       freq_in,
  output logic [ADDR_W-1:0] note_counter,
  output logic              ld_play,
  output logic              next_note_en,
  output logic              audio_out,
  output logic              busy,
  output logic              done
);

  localparam int MAX_DUR = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DUR_W   = $clog2(MAX_DUR) + 1;

  localparam logic [DUR_W-1:0]  LOAD_LAST = DUR_W'(LOAD_CYCLES - 1);
  localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_NOTES - 1);
  localparam logic [ADDR_W-1:0] SLOT_ONE  = ADDR_W'(1);

  player_state_t     state_q;
  logic [DUR_W-1:0]  dur_q;
  logic [ADDR_W-1:0] note_counter_q;
  logic [31:0]       freq_q;
  logic              ld_play_q;
  logic              busy_q;
  logic              next_note_en_q;
  logic              done_q;
  logic              tone_en;
  logic              wave;

  // The generator only runs on edges that stay inside TONE. Holding it off on
  // the entry edge keeps the first tone cycle low with a zero count, and
  // holding it off on the exit or stop edge puts the output low in the same
  // cycle the state leaves TONE.
  assign tone_en = (state_q == TONE) && !stop && (dur_q != NOTE_LAST);

  always_ff @(posedge clk) begin
    if (!reset || stop) begin
      state_q        <= IDLE;
      dur_q          <= '0;
      note_counter_q <= '0;
      freq_q         <= 32'd0;
      ld_play_q      <= 1'b0;
      busy_q         <= 1'b0;
      next_note_en_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      next_note_en_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (play) begin
            state_q        <= LOAD;
            dur_q          <= '0;
            note_counter_q <= '0;
            ld_play_q      <= 1'b1;
            busy_q         <= 1'b1;
          end
        end
        LOAD: begin
          if (dur_q == LOAD_LAST) begin
            freq_q         <= freq_in;
            state_q        <= TONE;
            dur_q          <= '0;
            next_note_en_q <= 1'b1;
          end else begin
            dur_q <= dur_q + DUR_ONE;
          end
        end
        TONE: begin
          if (dur_q == NOTE_LAST) begin
            state_q <= GAP;
            dur_q   <= '0;
          end else begin
            dur_q <= dur_q + DUR_ONE;
          end
        end
        GAP: begin
          if (dur_q == GAP_LAST) begin
            dur_q <= '0;
            if (note_counter_q != LAST_SLOT) begin
              note_counter_q <= note_counter_q + SLOT_ONE;
              state_q        <= LOAD;
            end else if (loop_en) begin
              note_counter_q <= '0;
              state_q        <= LOAD;
            end else begin
              note_counter_q <= '0;
              state_q        <= IDLE;
              ld_play_q      <= 1'b0;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
            end
          end else begin
            dur_q <= dur_q + DUR_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .enable      (tone_en),
    .half_period (freq_q),
    .wave        (wave)
  );

  assign note_counter = note_counter_q;
  assign ld_play      = ld_play_q;
  assign next_note_en = next_note_en_q;
  assign audio_out    = wave;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - self-checking bench for note_player
module tb_note_player;

  localparam int NOTE_C = 8;
  localparam int GAP_C  = 2;
  localparam int LOAD_C = 2;
  localparam int NUM_N  = 4;
  localparam int AW     = 2;
  localparam int PERIOD = LOAD_C + NOTE_C + GAP_C;

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          stop;
  logic          loop_en;
  logic [31:0]   freq_in = 32'd0;
  logic [AW-1:0] note_counter;
  logic          ld_play;
  logic          next_note_en;
  logic          audio_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int mem [NUM_N] = '{2, 0, 1, 3};

  bit m_active = 1'b0;
  int m_t      = 0;
  bit m_done   = 1'b0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  note_player #(
    .NUM_NOTES   (NUM_N),
    .ADDR_W      (AW),
    .NOTE_CYCLES (NOTE_C),
    .GAP_CYCLES  (GAP_C),
    .LOAD_CYCLES (LOAD_C)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .stop         (stop),
    .loop_en      (loop_en),
    .freq_in      (freq_in),
    .note_counter (note_counter),
    .ld_play      (ld_play),
    .next_note_en (next_note_en),
    .audio_out    (audio_out),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: m_t counts edges since the play edge; each slot takes PERIOD edges.
  // Memory: real data appears one cycle before the latch edge, junk otherwise.
  always @(posedge clk) begin
    m_done = 1'b0;
    if (!reset || stop) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (play) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else begin
      m_t++;
      if (m_t == NUM_N * PERIOD) begin
        if (loop_en) m_t = 0;
        else begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
    if (m_active && (m_t % PERIOD) == LOAD_C - 1) freq_in <= 32'(mem[note_counter]);
    else                                          freq_in <= 32'd5;
  end

  always @(negedge clk) begin
    int   slot;
    int   ph;
    int   f;
    int   j;
    logic e_audio;
    if (chk_en) begin
      if (m_active) begin
        slot    = m_t / PERIOD;
        ph      = m_t % PERIOD;
        f       = mem[slot];
        j       = ph - LOAD_C;
        e_audio = 1'b0;
        if (ph >= LOAD_C && ph < LOAD_C + NOTE_C && f != 0) e_audio = ((j / f) % 2) == 1;
        chk("m_nc",    32'(note_counter), 32'(slot));
        chk("m_busy",  32'(busy),         32'd1);
        chk("m_ld",    32'(ld_play),      32'd1);
        chk("m_nne",   32'(next_note_en), 32'(ph == LOAD_C));
        chk("m_audio", 32'(audio_out),    32'(e_audio));
        chk("m_done",  32'(done),         32'd0);
      end else begin
        chk("m_nc",    32'(note_counter), 32'd0);
        chk("m_busy",  32'(busy),         32'd0);
        chk("m_ld",    32'(ld_play),      32'd0);
        chk("m_nne",   32'(next_note_en), 32'd0);
        chk("m_audio", 32'(audio_out),    32'd0);
        chk("m_done",  32'(done),         32'(m_done));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_pass(input bit hold);
    int         nne[$];
    int         done_k[$];
    int         ncs[$];
    logic [7:0] a0;
    logic [7:0] a1;
    int         exp_nne [4] = '{2, 14, 26, 38};
    int         exp_nc  [5] = '{0, 1, 2, 3, 0};
    a0 = 8'd0;
    a1 = 8'd0;
    play    = 1'b1;
    loop_en = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      step();
      if (k == 0 && !hold) play = 1'b0;
      if (next_note_en) nne.push_back(k);
      if (done) done_k.push_back(k);
      if (k >= 2 && k <= 9)   a0[k-2]  = audio_out;
      if (k >= 14 && k <= 21) a1[k-14] = audio_out;
      if (k % 12 == 0 && k <= 48) ncs.push_back(int'(note_counter));
      if (hold && k == 48) chk("hold_idle_busy", 32'(busy), 32'd0);
      if (hold && k == 49) begin
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_nc", 32'(note_counter), 32'd0);
      end
    end
    chk("nne_count", 32'(nne.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("nne_offset", (i < nne.size()) ? 32'(nne[i]) : 32'hFFFF, 32'(exp_nne[i]));
    chk("done_count", 32'(done_k.size()), 32'd1);
    chk("done_offset", (done_k.size() > 0) ? 32'(done_k[0]) : 32'hFFFF, 32'd48);
    chk("slot0_audio", 32'(a0), 32'hCC);
    chk("slot1_audio", 32'(a1), 32'h00);
    for (int i = 0; i < 5; i++) chk("nc_seq", (i < ncs.size()) ? 32'(ncs[i]) : 32'hFFFF, 32'(exp_nc[i]));
    play = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b0;
    play    = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_audio", 32'(audio_out),    32'd0);
    chk("rst_nc",    32'(note_counter), 32'd0);
    chk("rst_done",  32'(done),         32'd0);
    reset = 1'b1;
    step();

    // Reset in the middle of slot 0's tone while audio is high.
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (4) step();
    chk("pre_rst_audio", 32'(audio_out), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_busy",  32'(busy),         32'd0);
    chk("mid_rst_audio", 32'(audio_out),    32'd0);
    chk("mid_rst_nc",    32'(note_counter), 32'd0);
    repeat (2) step();

    run_pass(1'b0);
    run_pass(1'b1);

    // Looping: loop_en only present on the last GAP cycle.
    play = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      step();
      if (k == 0) play = 1'b0;
      if (k == 47) loop_en = 1'b1;
      if (k == 48) begin
        loop_en = 1'b0;
        chk("loop_nc",   32'(note_counter), 32'd0);
        chk("loop_busy", 32'(busy),         32'd1);
        chk("loop_done", 32'(done),         32'd0);
      end
      if (k == 50) chk("loop_nne", 32'(next_note_en), 32'd1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // Stop together with play during slot 2's tone.
    play = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (k == 0) play = 1'b0;
      if (k == 30) begin
        stop = 1'b1;
        play = 1'b1;
      end
      if (k == 31) begin
        stop = 1'b0;
        play = 1'b0;
        chk("stop_busy", 32'(busy),         32'd0);
        chk("stop_nc",   32'(note_counter), 32'd0);
        chk("stop_done", 32'(done),         32'd0);
      end
      if (k == 40) chk("stop_norestart", 32'(busy), 32'd0);
    end

    repeat (3) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
